// File: rtl/systemizer_seq.sv
// Sequencer for the systemizer core: load host matrix, run the core, retry on fail, unload result.
// Optional watchdog on the core run, enabled with `define SYS_TIMEOUT_EN.
module systemizer_seq #(
    parameter int unsigned N         = 4,
    parameter int unsigned L         = 8,
    parameter int unsigned K         = 16,
    parameter int unsigned M         = 3,
    parameter int unsigned BLOCK     = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 4096,
    localparam int unsigned EW       = $clog2(M),
    localparam int unsigned DW       = BLOCK * EW,
    localparam int unsigned DEPTH    = (L * K) / BLOCK,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          reload_req,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          sys_start,
    input  logic          sys_done,
    input  logic          sys_fail,
    input  logic          sys_success,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [DW-1:0] sys_data_in,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [DW-1:0] sys_data_out,
    output logic          busy,
    output logic [1:0]    status,
    output logic [RW-1:0] retry_cnt
);

    if (N == 0 || TIMEOUT == 0 || DEPTH * BLOCK != L * K) begin : g_param_check
        $error("systemizer_seq: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StWait,
        StUnload,
        StDoneOk,
        StDoneErr
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic [AW-1:0]   rcnt_q, rcnt_d;
    logic [AW-1:0]   ocnt_q, ocnt_d;
    logic            rd_all_q, rd_all_d;
    logic [1:0]      status_q, status_d;
    logic [RW-1:0]   retry_q, retry_d;

    // Two-entry result FIFO fed by the core read port one cycle after each read.
    logic [DW-1:0]   fifo_q [2];
    logic            wptr_q, rptr_q;
    logic [1:0]      fcnt_q;
    logic            rd_pend_q;
    logic            push, pop;
    logic [2:0]      occupancy;

`ifdef SYS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wd_q, wd_d;
`endif

    assign push      = rd_pend_q;
    assign out_valid = (fcnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_q[rptr_q] : '0;
    assign out_last  = out_valid && (ocnt_q == LastAddr);
    assign busy      = !(state_q inside {StIdle, StDoneOk, StDoneErr});
    assign status    = status_q;
    assign retry_cnt = retry_q;
    assign occupancy = {1'b0, fcnt_q} + {2'b00, rd_pend_q};

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        ocnt_d      = ocnt_q;
        rd_all_d    = rd_all_q;
        status_d    = status_q;
        retry_d     = retry_q;
        in_ready    = 1'b0;
        reload_req  = 1'b0;
        sys_start   = 1'b0;
        sys_wr_en   = 1'b0;
        sys_wr_addr = '0;
        sys_data_in = '0;
        sys_rd_en   = 1'b0;
        sys_rd_addr = '0;
`ifdef SYS_TIMEOUT_EN
        wd_d        = wd_q;
`endif

        unique case (state_q)
            StIdle, StDoneOk, StDoneErr: begin
                if (cmd_start) begin
                    state_d  = StLoad;
                    status_d = 2'd0;
                    retry_d  = '0;
                end
            end

            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sys_wr_en   = 1'b1;
                    sys_wr_addr = wcnt_q;
                    sys_data_in = in_data;
                    if (wcnt_q == LastAddr) begin
                        wcnt_d  = '0;
                        state_d = StRun;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end

            StRun: begin
                sys_start = 1'b1;
                state_d   = StWait;
`ifdef SYS_TIMEOUT_EN
                wd_d      = '0;
`endif
            end

            StWait: begin
                if (sys_done && sys_success) begin
                    state_d = StUnload;
                end else if (sys_done && (sys_fail || !sys_success)) begin
                    // A done with no flag set is handled as a failure.
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d    = retry_q + 1'b1;
                        reload_req = 1'b1;
                        state_d    = StLoad;
                    end else begin
                        state_d  = StDoneErr;
                        status_d = 2'd2;
                    end
                end else begin
`ifdef SYS_TIMEOUT_EN
                    if (wd_q == TW'(TIMEOUT - 1)) begin
                        state_d  = StDoneErr;
                        status_d = 2'd3;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
            end

            StUnload: begin
                // A slot freed by this cycle's pop can be refilled, giving one word per cycle.
                if (!rd_all_q && (occupancy < (3'd2 + {2'b00, pop}))) begin
                    sys_rd_en   = 1'b1;
                    sys_rd_addr = rcnt_q;
                    if (rcnt_q == LastAddr) begin
                        rcnt_d   = '0;
                        rd_all_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                if (pop) begin
                    if (ocnt_q == LastAddr) begin
                        ocnt_d   = '0;
                        rd_all_d = 1'b0;
                        state_d  = StDoneOk;
                        status_d = 2'd1;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            ocnt_q    <= '0;
            rd_all_q  <= 1'b0;
            status_q  <= 2'd0;
            retry_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            fcnt_q    <= 2'd0;
            rd_pend_q <= 1'b0;
`ifdef SYS_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            ocnt_q    <= ocnt_d;
            rd_all_q  <= rd_all_d;
            status_q  <= status_d;
            retry_q   <= retry_d;
            rd_pend_q <= sys_rd_en;
            if (push) begin
                fifo_q[wptr_q] <= sys_data_out;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
`ifdef SYS_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

endmodule

// File: tb/tb_systemizer_seq.sv
// Randomized scoreboard bench for systemizer_seq: behavioural core memory model, host driver,
// and an output monitor that pops expected words as the DUT presents them.
module tb_systemizer_seq;

    localparam int DEPTH     = 32;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, reload_req, out_valid, out_last;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       sys_start;
    logic       sys_done = 1'b0, sys_fail = 1'b0, sys_success = 1'b0;
    logic       sys_wr_en, sys_rd_en;
    logic [4:0] sys_wr_addr, sys_rd_addr;
    logic [7:0] sys_data_in;
    logic [7:0] sys_data_out = 8'h00;
    logic       busy;
    logic [1:0] status, retry_cnt;

    always #5 clk = ~clk;

    systemizer_seq dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload_req(reload_req), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sys_start(sys_start), .sys_done(sys_done), .sys_fail(sys_fail),
        .sys_success(sys_success), .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr),
        .sys_data_in(sys_data_in), .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr),
        .sys_data_out(sys_data_out), .busy(busy), .status(status), .retry_cnt(retry_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] outcome_q[$];  // {success, fail} per core run
    int         checks = 0;
    int         errors = 0;
    int         n_start = 0, n_reload = 0, n_rd = 0, n_last = 0;
    bit         bp_mode = 1'b0;
    bit         fixed_dly = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Core model: memory, in-order address checks, scripted done/outcome after a delay.
    initial begin : core_model
        logic [7:0] mem [DEPTH];
        int         wexp = 0, rexp = 0, dly = 0;
        bit         rd_pend = 1'b0;
        logic [4:0] ra = '0;
        logic [1:0] o;
        forever begin
            @(negedge clk);
            if (rst) begin
                dly = 0; rd_pend = 1'b0; wexp = 0; rexp = 0;
            end else begin
                if (sys_wr_en) begin
                    check("wr_addr", sys_wr_addr, wexp);
                    mem[sys_wr_addr] = sys_data_in;
                    wexp = (wexp + 1) % DEPTH;
                end
                rd_pend = sys_rd_en;
                if (sys_rd_en) begin
                    check("rd_addr", sys_rd_addr, rexp);
                    ra = sys_rd_addr;
                    rexp = (rexp + 1) % DEPTH;
                end
                if (sys_start) dly = fixed_dly ? 10 : $urandom_range(2, 20);
            end
            @(posedge clk);
            #1;
            sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
            sys_data_out = rd_pend ? (mem[ra] ^ 8'hA5) : 8'h00;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    if (outcome_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unscripted_start: got a core run, expected none");
                    end else begin
                        o = outcome_q.pop_front();
                        sys_done = 1'b1; sys_success = o[1]; sys_fail = o[0];
                    end
                end
            end
        end
    end

    // Output monitor: scoreboard pops, stall stability, outstanding read bound, event counts.
    initial begin : monitor
        bit         stall = 1'b0;
        logic [7:0] stall_data = '0;
        int         outstanding = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0; outstanding = 0;
            end else begin
                if (sys_start) n_start++;
                if (reload_req) n_reload++;
                if (sys_rd_en) begin n_rd++; outstanding++; end
                if (stall) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, stall_data);
                end
                if (out_valid && out_ready) begin
                    outstanding--;
                    if (out_last) n_last++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %0h, expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_last", out_last, e.last);
                    end
                end
                if (sys_rd_en) check("outstanding_le2", outstanding <= 2, 1'b1);
                stall = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic load_matrix(input bit seq, input bit success_attempt, input bit hold);
        logic [7:0] w [DEPTH];
        int i = 0;
        int cyc = 0;
        for (int k = 0; k < DEPTH; k++) begin
            w[k] = seq ? 8'(k) : 8'($urandom);
            if (success_attempt) exp_q.push_back('{data: w[k] ^ 8'hA5, last: (k == DEPTH - 1)});
        end
        while (i < DEPTH && cyc < 500) begin
            @(posedge clk);
            #1;
            cmd_start = 1'b0;
            in_valid = hold ? 1'b1 : ($urandom % 4 != 0);
            in_data = w[i];
            @(negedge clk);
            if (in_valid && in_ready) i++;
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("load_complete", i, DEPTH);
    endtask

    task automatic run_job(input int nfail, input bit succeed, input bit seq, input bit hold,
                           input bit bp, input bit fixed);
        int  starts, exp_status, exp_retry, s0, r0, rd0, l0, cyc;
        bit  ok;
        ok = succeed && (nfail <= MAX_RETRY);
        starts = ok ? nfail + 1 : MAX_RETRY + 1;
        exp_status = ok ? 1 : 2;
        exp_retry = ok ? nfail : MAX_RETRY;
        for (int a = 0; a < starts; a++)
            outcome_q.push_back((ok && a == nfail) ? {1'b1, 1'($urandom % 2)}
                                                   : {1'b0, 1'($urandom % 2)});
        bp_mode = bp; fixed_dly = fixed;
        s0 = n_start; r0 = n_reload; rd0 = n_rd; l0 = n_last;
        @(posedge clk);
        #1;
        cmd_start = 1'b1;
        for (int a = 0; a < starts; a++) begin
            load_matrix(seq && a == 0, ok && a == nfail, hold);
            cyc = 0;
            forever begin
                @(posedge clk);
                #1;
                if (in_ready || !busy || cyc > 3000) break;
                // Noise that must be ignored while busy and outside LOAD.
                cmd_start = ($urandom % 8 == 0);
                in_valid = 1'($urandom % 2);
                in_data = 8'($urandom);
                cyc++;
            end
            cmd_start = 1'b0;
            in_valid = 1'b0;
            check("attempt_in_time", cyc <= 3000, 1'b1);
            check("attempt_reload", in_ready, a < starts - 1);
        end
        bp_mode = 1'b0;
        @(negedge clk);
        check("status", status, exp_status);
        check("retry_cnt", retry_cnt, exp_retry);
        check("busy_done", busy, 1'b0);
        check("starts", n_start - s0, starts);
        check("reloads", n_reload - r0, starts - 1);
        check("reads", n_rd - rd0, ok ? DEPTH : 0);
        check("last_count", n_last - l0, ok ? 1 : 0);
        check("scoreboard_empty", exp_q.size(), 0);
        check("outcomes_used", outcome_q.size(), 0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int got;
        repeat (3) @(negedge clk);
        check("reset_outs_a", {in_ready, reload_req, out_valid, out_data, out_last, sys_start,
                               sys_wr_en, sys_wr_addr, sys_data_in}, 0);
        check("reset_outs_b", {sys_rd_en, sys_rd_addr, busy, status, retry_cnt}, 0);
        #2 rst = 1'b0;

        run_job(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);  // nominal 0x00..0x1F
        run_job(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // two fails then success
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // retries exhausted
        run_job(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // random backpressure

        // Reset in the middle of LOAD after ten accepted words.
        @(posedge clk);
        #1;
        cmd_start = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 10; c++) begin
            @(posedge clk);
            #1;
            cmd_start = 1'b0;
            in_valid = 1'b1;
            in_data = 8'(c);
            @(negedge clk);
            if (in_valid && in_ready) got++;
        end
        check("mid_load_words", got, 10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_outs_a", {in_ready, reload_req, out_valid, out_data, out_last, sys_start,
                                  sys_wr_en, sys_wr_addr, sys_data_in}, 0);
        check("midreset_outs_b", {sys_rd_en, sys_rd_addr, busy, status, retry_cnt}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_reset_quiet", {sys_start, sys_wr_en, busy}, 0);
        end
        in_valid = 1'b0;
        run_job(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        for (int j = 0; j < 4; j++)
            run_job($urandom_range(0, 4), 1'($urandom % 4 != 0), 1'b0, 1'b0,
                    1'($urandom % 2), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
